// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared definitions for the multi-cycle MIPS fetch stage.
//   - pc_src_e   : next-PC source select encodings
//   - IR_*       : instruction register field bit positions
//   - HALT_OP_DEF: default opcode that stops fetch
//   - sext_br_off: sign-extended, word-scaled branch offset
package mcpu_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_J   = 2'b10,
        PC_JR  = 2'b11
    } pc_src_e;

    localparam int IR_OP_MSB   = 31;
    localparam int IR_OP_LSB   = 26;
    localparam int IR_RS_MSB   = 25;
    localparam int IR_RS_LSB   = 21;
    localparam int IR_RT_MSB   = 20;
    localparam int IR_RT_LSB   = 16;
    localparam int IR_RD_MSB   = 15;
    localparam int IR_RD_LSB   = 11;
    localparam int IR_FN_MSB   = 5;
    localparam int IR_FN_LSB   = 0;
    localparam int IR_IMM_MSB  = 15;
    localparam int IR_IMM_LSB  = 0;
    localparam int IR_JT_MSB   = 25;
    localparam int IR_JT_LSB   = 0;

    localparam logic [5:0] HALT_OP_DEF = 6'h3F;

    function automatic logic [31:0] sext_br_off(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/mcpu_fetch_unit_next_pc_sel.sv
// next_pc_sel: combinational next-PC mux plus misalignment flag.
//   pc_q       in  current PC
//   pc4_q      in  PC+4 captured with the IR
//   jtarget    in  IR[25:0] (jump target; low 16 bits double as imm)
//   rs_data    in  register jump target
//   pc_src     in  source select (pc_src_e encoding)
//   next_pc    out selected next PC
//   misaligned out next_pc[1:0] != 0
module next_pc_sel
    import mcpu_pkg::*;
(
    input  logic [31:0] pc_q,
    input  logic [31:0] pc4_q,
    input  logic [25:0] jtarget,
    input  logic [31:0] rs_data,
    input  logic [1:0]  pc_src,
    output logic [31:0] next_pc,
    output logic        misaligned
);

    always_comb begin
        next_pc = pc_q + 32'd4;
        case (pc_src_e'(pc_src))
            PC_SEQ: next_pc = pc_q + 32'd4;
            PC_BR:  next_pc = pc4_q + sext_br_off(jtarget[15:0]);
            PC_J:   next_pc = {pc4_q[31:28], jtarget, 2'b00};
            PC_JR:  next_pc = rs_data;
            default: next_pc = pc_q + 32'd4;
        endcase
    end

    // Only a register target can actually be misaligned; checked uniformly anyway.
    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/mcpu_fetch_unit.sv
// mcpu_fetch_unit: instruction-fetch stage of the multi-cycle MIPS CPU.
// Holds PC, IR, PC+4 link value, retired counter and sticky halt/address-error.
//   clk, rst        clock, async active-low reset
//   PCWre, IRWrite  PC / IR write enables from control
//   PCSrc           next-PC select (00 seq, 01 branch, 10 jump, 11 jr)
//   rs_data         jr/jalr target
//   imem_rdata      instruction at imem_addr (combinational memory)
//   imem_addr,pc_q  current PC
//   pc4_q           PC+4 captured with the IR
//   Opcode..imm     decoded IR fields
//   halted,addr_err sticky status
//   retired         IR loads since reset
module mcpu_fetch_unit
    import mcpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = HALT_OP_DEF,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCWre,
    input  logic             IRWrite,
    input  logic [1:0]       PCSrc,
    input  logic [31:0]      rs_data,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      imem_addr,
    output logic [31:0]      pc_q,
    output logic [31:0]      pc4_q,
    output logic [5:0]       Opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [5:0]       func,
    output logic [15:0]      imm,
    output logic             halted,
    output logic             addr_err,
    output logic [CNT_W-1:0] retired
);

    logic [31:0]      ir_q, ir_d;
    logic [31:0]      pc_d, pc4_d;
    logic             halted_q, halted_d;
    logic             addr_err_q, addr_err_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic [31:0]      next_pc;
    logic             misaligned;

    next_pc_sel u_next_pc_sel (
        .pc_q       (pc_q),
        .pc4_q      (pc4_q),
        .jtarget    (ir_q[IR_JT_MSB:IR_JT_LSB]),
        .rs_data    (rs_data),
        .pc_src     (PCSrc),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    // All updates use pre-edge state, so a combined PCWre+IRWrite edge loads
    // the IR from the old PC while the PC moves on using the old IR/pc4.
    always_comb begin
        pc_d       = pc_q;
        pc4_d      = pc4_q;
        ir_d       = ir_q;
        halted_d   = halted_q;
        addr_err_d = addr_err_q;
        retired_d  = retired_q;
        if (!halted_q) begin
            if (ir_q[IR_OP_MSB:IR_OP_LSB] == HALT_OP)
                halted_d = 1'b1;
            if (PCWre) begin
                if (misaligned) begin
                    addr_err_d = 1'b1;
                    halted_d   = 1'b1;
                end else begin
                    pc_d = next_pc;
                end
            end
            if (IRWrite) begin
                ir_d      = imem_rdata;
                pc4_d     = pc_q + 32'd4;
                retired_d = retired_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            pc4_q      <= RESET_PC + 32'd4;
            ir_q       <= '0;
            halted_q   <= 1'b0;
            addr_err_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            pc_q       <= pc_d;
            pc4_q      <= pc4_d;
            ir_q       <= ir_d;
            halted_q   <= halted_d;
            addr_err_q <= addr_err_d;
            retired_q  <= retired_d;
        end
    end

    assign imem_addr = pc_q;
    assign Opcode    = ir_q[IR_OP_MSB:IR_OP_LSB];
    assign rs        = ir_q[IR_RS_MSB:IR_RS_LSB];
    assign rt        = ir_q[IR_RT_MSB:IR_RT_LSB];
    assign rd        = ir_q[IR_RD_MSB:IR_RD_LSB];
    assign func      = ir_q[IR_FN_MSB:IR_FN_LSB];
    assign imm       = ir_q[IR_IMM_MSB:IR_IMM_LSB];
    assign halted    = halted_q;
    assign addr_err  = addr_err_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_mcpu_fetch_unit.sv
module tb_mcpu_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        PCWre = 1'b0, IRWrite = 1'b0;
    logic [1:0]  PCSrc = 2'b00;
    logic [31:0] rs_data = '0;
    logic [31:0] imem_rdata, imem_addr, pc_q, pc4_q;
    logic [5:0]  Opcode, func;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic        halted, addr_err;
    logic [31:0] retired;

    logic [31:0] mem [64];
    assign imem_rdata = mem[imem_addr[7:2]];

    always #5 clk = ~clk;

    mcpu_fetch_unit dut (
        .clk(clk), .rst(rst), .PCWre(PCWre), .IRWrite(IRWrite), .PCSrc(PCSrc),
        .rs_data(rs_data), .imem_rdata(imem_rdata), .imem_addr(imem_addr),
        .pc_q(pc_q), .pc4_q(pc4_q), .Opcode(Opcode), .rs(rs), .rt(rt), .rd(rd),
        .func(func), .imm(imm), .halted(halted), .addr_err(addr_err), .retired(retired)
    );

    typedef struct packed {
        logic [31:0] pc, pc4, ir;
        logic        hlt, err;
        logic [31:0] ret;
    } exp_t;

    exp_t        sb[$];
    exp_t        m;
    int          n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic chk_state(input string tag, input exp_t e);
        chk({tag, ".pc"},    pc_q, e.pc);
        chk({tag, ".addr"},  imem_addr, e.pc);
        chk({tag, ".pc4"},   pc4_q, e.pc4);
        chk({tag, ".ir"},    {Opcode, rs, rt, imm}, e.ir);
        chk({tag, ".rdfn"},  {21'd0, rd, func}, {21'd0, e.ir[15:11], e.ir[5:0]});
        chk({tag, ".halt"},  {31'd0, halted}, {31'd0, e.hlt});
        chk({tag, ".err"},   {31'd0, addr_err}, {31'd0, e.err});
        chk({tag, ".ret"},   retired, e.ret);
    endtask

    function automatic exp_t reset_state();
        exp_t r;
        r.pc = 32'h0; r.pc4 = 32'h4; r.ir = '0; r.hlt = 1'b0; r.err = 1'b0; r.ret = '0;
        return r;
    endfunction

    // Bench reference of one clock edge, straight from the behaviour description.
    task automatic step(input string tag, input logic pw, input logic iw,
                        input logic [1:0] src, input logic [31:0] rsd);
        exp_t        n;
        exp_t        got_e;
        logic [31:0] np;
        PCWre = pw; IRWrite = iw; PCSrc = src; rs_data = rsd;
        case (src)
            2'b00: np = m.pc + 32'd4;
            2'b01: np = m.pc4 + {{14{m.ir[15]}}, m.ir[15:0], 2'b00};
            2'b10: np = {m.pc4[31:28], m.ir[25:0], 2'b00};
            default: np = rsd;
        endcase
        n = m;
        if (!m.hlt) begin
            if (m.ir[31:26] == 6'h3F) n.hlt = 1'b1;
            if (pw) begin
                if (np[1:0] != 2'b00) begin n.err = 1'b1; n.hlt = 1'b1; end
                else n.pc = np;
            end
            if (iw) begin
                n.ir  = mem[m.pc[7:2]];
                n.pc4 = m.pc + 32'd4;
                n.ret = m.ret + 32'd1;
            end
        end
        m = n;
        sb.push_back(n);
        @(posedge clk);
        #1;
        PCWre = 1'b0; IRWrite = 1'b0;
        got_e = sb.pop_front();
        chk_state(tag, got_e);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000 + i * 32'h0101_0101;
        mem[0] = 32'h2108_0001;                 // addi
        mem[1] = 32'h0128_5020;                 // add
        mem[2] = 32'h8D2A_0010;                 // lw
        mem[3] = 32'h0800_0040;                 // j 0x40
        mem[4] = 32'h1000_FFFE;                 // beq imm -2
        mem[5] = 32'hFC00_0000;                 // halt opcode

        // reset state
        #12;
        m = reset_state();
        chk_state("reset", m);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        step("seq1", 1, 1, 2'b00, 0);
        step("seq2", 1, 1, 2'b00, 0);
        step("seq3", 1, 1, 2'b00, 0);
        chk("seq3.pc_c", pc_q, 32'hC);
        chk("seq3.ret3", retired, 32'd3);
        step("seq4", 1, 1, 2'b00, 0);
        step("ld_beq", 0, 1, 2'b00, 0);
        step("beq", 1, 0, 2'b01, 0);
        chk("beq.pc", pc_q, 32'hC);
        step("jr_hi", 1, 0, 2'b11, 32'h8000_000C);
        step("ld_j", 0, 1, 2'b00, 0);
        step("j", 1, 0, 2'b10, 0);
        chk("j.pc", pc_q, 32'h8000_0100);
        step("mis", 1, 0, 2'b11, 32'h0000_0102);
        chk("mis.err", {31'd0, addr_err}, 32'd1);
        step("mis_ir", 0, 1, 2'b00, 0);
        step("mis_pc", 1, 1, 2'b00, 0);

        // async reset mid-cycle
        #3; rst = 1'b0; #1;
        m = reset_state(); sb.delete();
        chk_state("rst_mid1", m);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) step("run", 1, 1, 2'b00, 0);
        step("ld_halt", 0, 1, 2'b00, 0);
        chk("ld_halt.nohalt", {31'd0, halted}, 32'd0);
        step("halt", 0, 0, 2'b00, 0);
        chk("halt.set", {31'd0, halted}, 32'd1);
        step("hfrz1", 1, 1, 2'b00, 0);
        step("hfrz2", 1, 0, 2'b11, 32'h100);
        chk("hfrz.ret", retired, 32'd6);

        #3; rst = 1'b0; #1;
        m = reset_state();
        chk_state("rst_mid2", m);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // PC wrap-around modulo 2^32
        step("jr_top", 1, 0, 2'b11, 32'hFFFF_FFFC);
        step("wrap", 1, 1, 2'b00, 0);
        chk("wrap.pc", pc_q, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mcpu_fetch_unit.md
# mcpu_fetch_unit

Instruction-fetch stage of the multi-cycle MIPS CPU. It holds the PC and instruction register (IR) and computes the next PC from the selected source. It drives instruction-memory addressing and feeds the decoded IR fields (`Opcode`, `func`, `rt`, `rs`, `rd`, `imm`) to the control unit and datapath. It also keeps a retired-instruction counter and sticky halt / address-error status.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `HALT_OP`, 6'h3F, opcode that halts fetch
- `CNT_W`, 32, width of the retired-instruction counter

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  reset; asynchronous, active-low (0 = reset)
- `PCWre`  in  1  PC write enable from control unit
- `IRWrite`  in  1  IR load enable from control unit
- `PCSrc`  in  2  next-PC source select
- `rs_data`  in  32  register-file rs value, used as jr/jalr target
- `imem_rdata`  in  32  instruction word at `imem_addr`; combinational read
- `imem_addr`  out  32  equals `pc_q`
- `pc_q`  out  32  current PC
- `pc4_q`  out  32  PC+4 captured with the IR; jal/jalr link value
- `Opcode`  out  6  IR[31:26]
- `rs`  out  5  IR[25:21]
- `rt`  out  5  IR[20:16]
- `rd`  out  5  IR[15:11]
- `func`  out  6  IR[5:0]
- `imm`  out  16  IR[15:0]
- `halted`  out  1  sticky; fetch stopped
- `addr_err`  out  1  sticky; misaligned next PC detected
- `retired`  out  CNT_W  count of IR loads since reset

## Operation
- Next-PC value (combinational):
  - `PCSrc` 00: `pc_q`+4
  - `PCSrc` 01: `pc4_q` + (sign-extend(`imm`) << 2)
  - `PCSrc` 10: {`pc4_q`[31:28], IR[25:0], 2'b00}
  - `PCSrc` 11: `rs_data`
- All 32-bit arithmetic wraps modulo 2^32. No carry or overflow is reported.
- PC update: on an edge with `PCWre`=1, not halted and next-PC[1:0]==0, `pc_q` ← next-PC.
- Misaligned target: on an edge with `PCWre`=1 and next-PC[1:0]!=0:
  - `pc_q` holds
  - `addr_err` ← 1 and `halted` ← 1
- IR load: on an edge with `IRWrite`=1 and not halted:
  - IR ← `imem_rdata`
  - `pc4_q` ← `pc_q`+4
  - `retired` ← `retired`+1, wrapping at 2^CNT_W
- Halt: when IR[31:26]==`HALT_OP`, `halted` ← 1 on the next edge.
- While halted:
  - `PCWre` and `IRWrite` are ignored
  - all state freezes until reset
- Simultaneous `PCWre` and `IRWrite` on one edge:
  - IR captures `imem_rdata` at the pre-edge `pc_q`
  - `pc4_q` ← pre-edge `pc_q`+4
  - `pc_q` ← next-PC computed from the pre-edge IR and `pc4_q`

## Timing
- Reset values (async, immediate on `rst`=0):
  - `pc_q`=`RESET_PC`, `pc4_q`=`RESET_PC`+4
  - IR=0, so every field output is 0
  - `halted`=0, `addr_err`=0, `retired`=0
- Reset release is synchronous to `clk`. The first loading edge is the first rising edge with `rst`=1.
- `imem_addr` tracks `pc_q` with zero latency. `imem_rdata` must be valid in the same cycle.
- Field outputs change 1 cycle after an `IRWrite` edge.
- `pc_q` changes 1 cycle after a `PCWre` edge.
- `halted` asserts exactly 1 edge after the halt opcode appears in the IR.
- Reset mid-instruction discards the IR and PC immediately. No partial update survives.

## Structure
- Shared package `mcpu_pkg`:
  - `PCSrc` encodings (`PC_SEQ`, `PC_BR`, `PC_J`, `PC_JR`)
  - IR field bit positions
  - `HALT_OP` default
- One combinational sub-module, `next_pc_sel`, computes next-PC and the misalignment flag.
- The top level holds all registers: PC, IR, `pc4_q`, counter and status.

## Test plan
- Reset then 3 `IRWrite` edges with `PCWre`=1, `PCSrc`=00 → `pc_q`=0xC, `retired`=3, IR=third word.
- IR=beq with imm=0xFFFE, `pc4_q`=0x14, `PCSrc`=01, `PCWre`=1 → `pc_q`=0x0C.
- IR=j with target 0x0000040, `pc4_q`=0x8000_0010, `PCSrc`=10 → `pc_q`=0x8000_0100.
- `PCSrc`=11, `rs_data`=0x0000_0102, `PCWre`=1 → `pc_q` unchanged, `addr_err`=1, `halted`=1, later `IRWrite` ignored.
- Load IR with opcode 0x3F → `halted`=1 next edge, then `PCWre`/`IRWrite` pulses leave `pc_q`/`retired` frozen. Assert `rst`=0 mid-cycle → all outputs return to reset values before the next edge.
